// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH programmable clock-enable dividers with glitch-free boundary reload, pulse/square output and shared sync
module clk_div_bank #(
  parameter int NCH = 4,
  parameter int WIDTH = 16,
  parameter int DEF_DIV = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NCH-1:0]   i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CHW-1:0]   i_wr_ch,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic             i_wr_mode,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_pend
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, sdiv_q, sdiv_d, d;
    logic mode_q, mode_d, smode_q, smode_d, pend_q, pend_d, tick_q, tick_d, clk_q, clk_d;
    logic bnd, hit, now;
    assign d = (div_q < WIDTH'(2)) ? WIDTH'(2) : div_q;
    assign bnd = i_en[c] && (cnt_q == d);
    assign hit = i_wr && (i_wr_ch == CHW'(c));
    assign now = i_sync || bnd;
    always_comb begin
      cnt_d = (!i_en[c] || now) ? WIDTH'(1) : cnt_q + WIDTH'(1);
      tick_d = bnd && !i_sync;
      clk_d = mode_q ? (i_en[c] && (cnt_q <= (d >> 1))) : tick_d;
      div_d = div_q;
      mode_d = mode_q;
      sdiv_d = sdiv_q;
      smode_d = smode_q;
      pend_d = pend_q;
      if (hit && (now || !i_en[c])) begin
        div_d = i_wr_div;
        mode_d = i_wr_mode;
        pend_d = 1'b0;
      end else if (hit) begin
        sdiv_d = i_wr_div;
        smode_d = i_wr_mode;
        pend_d = 1'b1;
      end else if (now && pend_q) begin
        div_d = sdiv_q;
        mode_d = smode_q;
        pend_d = 1'b0;
      end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= WIDTH'(1);
        div_q <= WIDTH'(DEF_DIV);
        sdiv_q <= WIDTH'(DEF_DIV);
        mode_q <= 1'b0;
        smode_q <= 1'b0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        div_q <= div_d;
        sdiv_q <= sdiv_d;
        mode_q <= mode_d;
        smode_q <= smode_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        clk_q <= clk_d;
      end
    end
    assign o_tick[c] = tick_q;
    assign o_clk[c] = clk_q;
    assign o_pend[c] = pend_q;
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: table-driven and scoreboarded check of clk_div_bank
module tb_clk_div_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] en = '0;
  logic sync = 1'b0, wr = 1'b0, mode = 1'b0;
  logic [1:0] ch = '0;
  logic [15:0] div = '0;
  logic [3:0] tick, oclk, pend;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  clk_div_bank #(.NCH(4), .WIDTH(16), .DEF_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync), .i_wr(wr),
    .i_wr_ch(ch), .i_wr_div(div), .i_wr_mode(mode),
    .o_tick(tick), .o_clk(oclk), .o_pend(pend)
  );
  typedef struct {
    logic [3:0] en; logic sync; logic wr; logic [1:0] ch; logic [15:0] div; logic mode;
    logic chk; logic [3:0] tick; logic [3:0] clk; logic [3:0] pend; string name;
  } vec_t;
  typedef struct {
    logic chk; logic [3:0] tick; logic [3:0] clk; logic [3:0] pend; string name;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t mx;
  function automatic vec_t mk(logic [3:0] e, logic s, logic w, logic [1:0] c, logic [15:0] d,
                              logic m, logic k, logic [3:0] t, logic [3:0] o, logic [3:0] p, string n);
    vec_t v;
    v.en = e; v.sync = s; v.wr = w; v.ch = c; v.div = d; v.mode = m;
    v.chk = k; v.tick = t; v.clk = o; v.pend = p; v.name = n;
    return v;
  endfunction
  task automatic chk1(string n, string f, logic [3:0] got, logic [3:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s %s got %b want %b", n, f, got, want);
  endtask
  task automatic drive(vec_t v);
    exp_t x;
    @(negedge clk);
    en = v.en; sync = v.sync; wr = v.wr; ch = v.ch; div = v.div; mode = v.mode;
    x.chk = v.chk; x.tick = v.tick; x.clk = v.clk; x.pend = v.pend; x.name = v.name;
    sb.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      if (mx.chk) begin
        chk1(mx.name, "tick", tick, mx.tick);
        chk1(mx.name, "clk", oclk, mx.clk);
        chk1(mx.name, "pend", pend, mx.pend);
      end
    end
  end
  initial begin
    for (int k = 0; k < 8; k++) begin
      logic [3:0] t;
      t = (k == 3 || k == 7) ? 4'hF : 4'h0;
      tbl.push_back(mk(4'hF, 0, 0, 0, 0, 0, 1, t, t, 4'h0, "dflt"));
    end
    tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, "dflt_dis"));
    tbl.push_back(mk(4'h0, 0, 1, 1, 16'd5, 1, 1, 4'h0, 4'h0, 4'h0, "sq_wr"));
    for (int k = 0; k < 10; k++) begin
      logic [3:0] t, o;
      o = (k % 5 < 2) ? 4'b0010 : 4'b0000;
      t = (k % 5 == 4) ? 4'b0010 : 4'b0000;
      tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1, t, o, 4'h0, "square"));
    end
    tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, "sq_dis"));
    repeat (2) @(negedge clk);
    chk1("reset", "tick", tick, 4'h0);
    chk1("reset", "clk", oclk, 4'h0);
    chk1("reset", "pend", pend, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) drive(tbl[i]);
    drive(mk(4'h0, 0, 1, 0, 16'd8, 0, 1, 4'h0, 4'h0, 4'h0, "wr8"));
    for (int k = 0; k < 39; k++) begin
      logic w; logic [15:0] d; logic [3:0] t, p;
      w = k inside {3, 19, 27, 29};
      d = (k == 3) ? 16'd3 : (k == 19) ? 16'd6 : (k == 27) ? 16'd10 : 16'd7;
      t = (k inside {7, 10, 13, 16, 19, 25, 31, 38}) ? 4'b0001 : 4'b0000;
      p = (k inside {[3:6], [27:30]}) ? 4'b0001 : 4'b0000;
      drive(mk(4'b0001, 0, w, 0, d, 0, 1, t, t, p, "reload"));
    end
    drive(mk(4'h0, 0, 1, 0, 16'd4, 0, 1, 4'h0, 4'h0, 4'h0, "s_wr0"));
    drive(mk(4'h0, 0, 1, 2, 16'd6, 0, 1, 4'h0, 4'h0, 4'h0, "s_wr2"));
    for (int k = 0; k < 24; k++) begin
      int j; logic [3:0] t;
      j = k - 11;
      t = {1'b0, j inside {6, 12}, 1'b0, j inside {4, 8, 12}};
      drive(mk(k < 3 ? 4'b0001 : 4'b0101, k == 11, 0, 0, 0, 0, k >= 11, t, t, 4'h0, "sync"));
    end
    drive(mk(4'h0, 0, 1, 3, 16'd0, 0, 1, 4'h0, 4'h0, 4'h0, "c_wr0"));
    for (int k = 0; k < 4; k++) begin
      logic [3:0] t;
      t = (k % 2 == 1) ? 4'b1000 : 4'b0000;
      drive(mk(4'b1000, 0, 0, 0, 0, 0, 1, t, t, 4'h0, "clamp0"));
    end
    drive(mk(4'h0, 0, 1, 3, 16'd1, 0, 1, 4'h0, 4'h0, 4'h0, "c_wr1"));
    for (int k = 0; k < 4; k++) begin
      logic [3:0] t;
      t = (k % 2 == 1) ? 4'b1000 : 4'b0000;
      drive(mk(4'b1000, 0, 0, 0, 0, 0, 1, t, t, 4'h0, "clamp1"));
    end
    drive(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, "c_dis"));
    drive(mk(4'b1010, 0, 1, 1, 16'd9, 1, 1, 4'b0000, 4'b0010, 4'b0010, "r_a"));
    drive(mk(4'b1010, 0, 0, 0, 0, 0, 1, 4'b1000, 4'b1010, 4'b0010, "r_b"));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst", "tick", tick, 4'h0);
    chk1("async_rst", "clk", oclk, 4'h0);
    chk1("async_rst", "pend", pend, 4'h0);
    @(negedge clk);
    en = 4'h0; wr = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] t;
      t = (k == 3 || k == 7) ? 4'hF : 4'h0;
      drive(mk(4'hF, 0, 0, 0, 0, 0, 1, t, t, 4'h0, "rst_def"));
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of `NCH` independent programmable clock dividers. Each channel has a runtime-loadable divisor and a selectable pulse or square output mode. Divisor changes are glitch-free because they apply only at a period boundary. A shared sync strobe phase-aligns all channels. The block sits between the system clock and slow peripherals (scan, debounce, display, 1 Hz timebase); it generates enables and does not drive real clock trees.

## Interface
- `NCH`, 4: number of channels (≥1).
- `WIDTH`, 16: divisor/counter width.
- `DEF_DIV`, 4: reset divisor for every channel.
- `CHW`, `$clog2(NCH)` (min 1): channel-select width (localparam).

Ports:
- `i_clk` in 1: system clock; all logic on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_en` in NCH: per-channel run enable.
- `i_sync` in 1: one-cycle strobe that restarts all channel counters together.
- `i_wr` in 1: write strobe for the divisor/mode register.
- `i_wr_ch` in CHW: target channel. Writes to a channel ≥ NCH are ignored.
- `i_wr_div` in WIDTH: new divisor.
- `i_wr_mode` in 1: new mode. 0 = pulse, 1 = square.
- `o_tick` out NCH: registered one-cycle pulse, once per period.
- `o_clk` out NCH: registered divided output (pulse or square per mode).
- `o_pend` out NCH: write accepted but not yet applied.

## Operation
- Per-channel state:
  - Active divisor `div` and active mode `mode`.
  - Shadow divisor and shadow mode.
  - Pend flag.
  - Counter `cnt`, range 1..d.
- Effective divisor: `d = (div < 2) ? 2 : div`. Divisor values 0 and 1 clamp to 2.
- Reset (async): `cnt = 1`, `div = DEF_DIV`, `mode = 0`, pend = 0, `o_tick = 0`, `o_clk = 0`, `o_pend = 0`.
- Disabled channel (`i_en[c] = 0`):
  - `cnt` forced to 1.
  - `o_tick[c]` and `o_clk[c]` are driven 0 on the next edge.
- Enabled channel: at each edge, `cnt` advances by 1; when `cnt == d` it wraps to 1.
- Period boundary: an enabled edge where `cnt == d`.
  - If pend is set, shadow → active and pend clears.
- Write to channel c:
  - **Enabled, no boundary this edge:** value goes to the shadow and pend sets. A later write before the boundary overwrites the shadow; last write wins.
  - **Boundary on the same edge:** the written value goes directly to active. Pend stays 0, and any older shadow is discarded.
  - **Channel disabled:** the value goes directly to active and pend stays 0.
- `i_sync`:
  - All enabled counters load 1 on that edge.
  - Every pending shadow is applied, and all pend flags clear.
  - A write on the same edge is applied directly.
  - `i_sync` takes priority over the wrap/compare result for that edge.
- `o_tick[c]`: on each edge, registers `en && cnt == d`. With `i_sync` asserted, the tick is suppressed.
- `o_clk[c]`:
  - Pulse mode (`mode = 0`): equals `o_tick[c]` (same register value).
  - Square mode (`mode = 1`): on each edge, registers `en && (cnt <= d>>1)`.
  - Square duty: high for d>>1 cycles, low for d−(d>>1) cycles. Odd divisors are low one cycle longer.
- Width rule: the counter is WIDTH bits; the maximum period is 2^WIDTH−1. All compares are unsigned.

## Timing
- First enabled edge E0 (the first edge at which `i_en[c] = 1` is sampled):
  - `cnt` goes 1→2 at E0.
  - Square `o_clk` rises at E0.
  - First `o_tick` rises at edge E0 + d−1 and lasts one cycle.
  - `o_tick` repeats every d cycles thereafter.
- After an `i_sync` edge S, each enabled channel's next tick rises at S + d, using the new d if a shadow was applied.
- A divisor change applied at a boundary takes effect in the very next period; there are no short or merged pulses.
- `o_pend` latency:
  - Rises on the edge after the write.
  - Falls on the boundary edge that applies the shadow.
- Disable: the output is 0 one edge after `i_en` falls. Re-enable restarts from E0 timing.
- Channels are fully independent apart from the shared write bus and `i_sync`.

## Test plan
- **Reset/defaults:** release `i_rst_n` with `DEF_DIV = 4` and all `i_en = 1` → `o_tick` pulses on every channel 3 edges after enable, then every 4 cycles. Pulse mode gives `o_clk == o_tick`.
- **Square duty:** write ch1 div=5, mode=1 while disabled, then enable → `o_clk[1]` high 2 cycles, low 3 cycles, repeating; `o_tick[1]` once per 5 cycles.
- **Glitch-free reload:** ch0 running div=8; write div=3 mid-period → `o_pend[0] = 1` until the boundary, then 0. The current period stays 8 cycles, and the following periods are exactly 3 cycles.
- **Write on boundary and last-wins:**
  - Write div=6 on the boundary edge → applied immediately and pend never sets.
  - Two writes (10 then 7) in one period → the next period is 7.
- **Sync alignment:** ch0 div=4 and ch2 div=6 at arbitrary phases; pulse `i_sync` at edge S → both counters restart, with ticks at S+4 and S+6. Both tick together every 12 cycles.
- **Clamp and async reset mid-count:**
  - div=0 and div=1 → period 2.
  - Assert `i_rst_n` low mid-period → all outputs 0 immediately without a clock edge, and div returns to `DEF_DIV`.
